entrada_chaves: RTL

User-input front end for the DE2 processor board: the input-side counterpart of the register-to-HEX display path. Synchronizes and debounces a pushbutton and the data switches, and captures the switch word on each clean press. Delivers that word to the processor over a valid/ready handshake, and also emits a single-cycle step pulse for single-step clock enable. Sits between board pins (SW, KEY) and the processor core, inside the board-level pinning module.

---
 rtl/entrada_pkg.sv | 21 ++
 rtl/sincronizador_2ff.sv | 24 ++
 rtl/entrada_chaves.sv | 139 +++++++++++++
 3 files changed

// File: rtl/entrada_pkg.sv
// Shared definitions for the switch/pushbutton input front end.
package entrada_pkg;

  localparam int unsigned DATA_W_DEF          = 16;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned COUNT_W             = 8;

  // Debounce FSM encodings
  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_APERTO = 2'd1,
    APERTO      = 2'd2,
    CONF_SOLTO  = 2'd3
  } estado_t;

  // Debounced key level implied by an FSM state (confirming a release is still pressed)
  function automatic logic nivel_pressionado(input estado_t e);
    return (e == APERTO) || (e == CONF_SOLTO);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
module sincronizador_2ff #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/entrada_chaves.sv
// Debounced pushbutton capture of the data switches, delivered over valid/ready
// with a single-cycle step pulse per accepted press.
module entrada_chaves
  import entrada_pkg::*;
#(
  parameter int unsigned DATA_W          = DATA_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  sw,
  input  logic               key_n,
  input  logic               rd_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               overrun,
  output logic               step,
  output logic               key_level,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              key_s;
  logic [DATA_W-1:0] sw_s;

  sincronizador_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_sinc_key (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  sincronizador_2ff #(
    .W       (DATA_W),
    .RST_VAL ({DATA_W{1'b0}})
  ) u_sinc_sw (
    .clock (clock),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  estado_t          estado, estado_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             aceite;

  // Debounce state and stability counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= SOLTO;
      cnt    <= '0;
    end else begin
      estado <= estado_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // A level change is accepted only after an unbroken run of opposite samples
  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    aceite     = 1'b0;
    case (estado)
      SOLTO: begin
        if (!key_s) begin
          estado_nxt = CONF_APERTO;
          cnt_nxt    = '0;
        end
      end
      CONF_APERTO: begin
        if (key_s) begin
          estado_nxt = SOLTO;
          cnt_nxt    = '0;
        end else if (cnt == CNT_ULT) begin
          estado_nxt = APERTO;
          cnt_nxt    = '0;
          aceite     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      APERTO: begin
        if (key_s) begin
          estado_nxt = CONF_SOLTO;
          cnt_nxt    = '0;
        end
      end
      CONF_SOLTO: begin
        if (!key_s) begin
          estado_nxt = APERTO;
          cnt_nxt    = '0;
        end else if (cnt == CNT_ULT) begin
          estado_nxt = SOLTO;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        estado_nxt = SOLTO;
        cnt_nxt    = '0;
      end
    endcase
  end

  // Capture register, handshake and press bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      overrun     <= 1'b0;
      step        <= 1'b0;
      key_level   <= 1'b0;
      press_count <= '0;
    end else begin
      step      <= aceite;
      key_level <= nivel_pressionado(estado_nxt);
      if (aceite) begin
        press_count <= press_count + COUNT_W'(1);
      end
      if (aceite && (!rd_valid || rd_ready)) begin
        rd_data  <= sw_s;
        rd_valid <= 1'b1;
        overrun  <= 1'b0;
      end else if (aceite) begin
        overrun <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule
